// File: rtl/cpu_io_pkg.sv
// Shared constants and helpers for the CPU I/O port stages (input and output FIFOs).
package cpu_io_pkg;

  localparam int CPU_DATA_WIDTH    = 16;
  localparam int IO_FIFO_DEPTH     = 8;
  localparam int IO_DROP_CNT_WIDTH = 8;

  // A CPU word as the program sees it: signed two's complement.
  typedef logic signed [CPU_DATA_WIDTH-1:0] cpu_word_t;

  // Number of address bits needed to index 'depth' entries (minimum 1).
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cpu_output_fifo_if.sv
// Bundle of the CPU write side, consumer handshake and status signals of the output FIFO.
interface cpu_output_fifo_if
  import cpu_io_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int DEPTH      = IO_FIFO_DEPTH,
  parameter int CNT_WIDTH  = IO_DROP_CNT_WIDTH
);

  localparam int CW = addr_width(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  cpu_wr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  drop_count;
  logic                  clear_ovf;

  // Producer/consumer side (CPU plus downstream consumer, or a bench).
  modport master (
    output cpu_data, cpu_wr, out_ready, clear_ovf,
    input  out_data, out_valid, full, empty, count, overflow, drop_count
  );

  // FIFO side.
  modport slave (
    input  cpu_data, cpu_wr, out_ready, clear_ovf,
    output out_data, out_valid, full, empty, count, overflow, drop_count
  );

endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset on contents.
module fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_output_fifo.sv
// First-word-fall-through output FIFO for CPU output words, with registered head/status
// outputs and a sticky overflow flag plus saturating count of words lost while full.
module cpu_output_fifo
  import cpu_io_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int DEPTH      = IO_FIFO_DEPTH,
  parameter int CNT_WIDTH  = IO_DROP_CNT_WIDTH
) (
  input  logic            CLK,
  input  logic            reset,
  cpu_output_fifo_if.slave bus
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DROP_MAX   = {CNT_WIDTH{1'b1}};

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Reads at the next head position so the output register can be loaded in one step.
  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (push & ~reset),
    .waddr (wr_ptr_q),
    .wdata (bus.cpu_data),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  // Handshake decode: a pop frees a slot, so a write into a full FIFO is accepted then.
  always_comb begin
    pop  = out_valid_q & bus.out_ready;
    push = bus.cpu_wr & (~full_q | pop);
    drop = bus.cpu_wr & full_q & ~pop;
  end

  // Pointer, occupancy and registered full/empty flags.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  // Next head word: the incoming word when it lands in an otherwise empty FIFO,
  // otherwise the stored word at the next read pointer; held when nothing is left.
  always_comb begin
    out_valid_d = (count_d != '0);
    out_data_d  = out_data_q;
    if (push && (count_q == CW'(pop))) begin
      out_data_d = bus.cpu_data;
    end else if (count_d != '0) begin
      out_data_d = ram_rdata;
    end
  end

  // Overflow tracking; a drop in the same cycle as a clear wins and restarts the count at 1.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clear_ovf) begin
        drop_count_d = CNT_WIDTH'(1);
      end else if (drop_count_q != DROP_MAX) begin
        drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end
    end else if (bus.clear_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // State registers; reset overrides every other input in its cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: doc/cpu_output_fifo.md
Name: cpu_output_fifo

Overview:
- Downstream stage of the CPU. Captures each signed 16-bit word the CPU writes to its output port, tagged by a one-cycle write strobe.
- Buffers the words in a small FIFO and presents them to a consumer (display driver, UART framer or bench monitor) over a valid/ready handshake.
- Flags and counts words lost when the buffer is full, so CPU output is never silently dropped.

Parameters:
- DATA_WIDTH, 16, width of a CPU output word (signed two's complement, passed through unmodified)
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2
- CNT_WIDTH, 8, width of the saturating drop counter

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_data  in  DATA_WIDTH  signed word from CPU outputWire
- cpu_wr  in  1  one-cycle strobe; cpu_data is valid this cycle
- out_data  out  DATA_WIDTH  head-of-FIFO word, signed
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts out_data this cycle
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: at least one word dropped since last clear
- drop_count  out  CNT_WIDTH  number of dropped words, saturating at all-ones
- clear_ovf  in  1  clears overflow and drop_count

Behaviour:
- Reset (sync, active-high): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, full=0, empty=1, overflow=0, drop_count=0. Storage contents are don't-care; stored words are discarded.
- Reset mid-operation: takes priority over every other input in that cycle; any cpu_wr in the same cycle is ignored.
- Push = cpu_wr and (not full, or pop this cycle).
- Pop = out_valid and out_ready.
- FIFO type: first-word-fall-through, with registered outputs.
- Latency: a word pushed at edge N into an empty FIFO has out_valid=1 and out_data=word after edge N. Write-to-visible latency is 1 cycle.
- Push and pop in the same cycle, not full: count unchanged, pointers both advance.
- Push and pop in the same cycle, full: the push is accepted because the pop frees a slot. count stays DEPTH, full stays 1, no drop.
- Empty with cpu_wr and out_ready both high: no pop (out_valid=0). The word becomes visible next cycle; count goes 0 to 1.
- Drop = cpu_wr and full and not pop. The word is discarded, storage is unchanged, overflow is set to 1, and drop_count increments by 1, saturating at 2^CNT_WIDTH-1.
- clear_ovf: next cycle overflow=0 and drop_count=0.
- clear_ovf coinciding with a drop: the set wins, giving overflow=1 and drop_count=1.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0 (AXI-style; no retraction).
- out_valid must never assert when count=0.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- full = (count==DEPTH) and empty = (count==0). Both are registered, with no combinational path from the inputs.
- No path from out_ready to out_valid in the same cycle.
- No arithmetic is performed on data. The signed interpretation is preserved bit-exact; no sign extension, since widths are equal.

Decomposition:
- Shared package cpu_io_pkg: CPU_DATA_WIDTH=16, IO_FIFO_DEPTH=8, IO_DROP_CNT_WIDTH=8, and a clog2-style address-width helper. These are reused by the matching input-port stage.
- One sub-module, fifo_ram: DEPTH x DATA_WIDTH, one write port and one asynchronous-read port, no reset on storage.
- Control, pointers, counters and the output register live in cpu_output_fifo.

Test Plan:
- Reset, then write 5 (cpu_wr one cycle) -> 1 cycle later out_valid=1, out_data=5, count=1. Pulse out_ready -> empty=1, out_valid=0.
- Push -3, 100, -32768, 32767 with out_ready=0 -> count=4. Drain with out_ready=1 -> outputs -3, 100, -32768, 32767 in order, each signed value bit-exact.
- Push 8 words (1..8) -> full=1. Push 9 and 10 -> overflow=1, drop_count=2, then drain yields 1..8 only.
- Full FIFO, cpu_wr=1 (value 42) and out_ready=1 same cycle -> no drop, count=8, and 42 appears last after draining.
- Force 300 drops -> drop_count=255 (saturated). Assert clear_ovf together with a further drop -> overflow=1, drop_count=1. Then clear_ovf alone -> both 0.
- Load 5 words, assert reset for one cycle alongside cpu_wr=1 -> count=0, empty=1, out_valid=0, overflow=0. A subsequent push of 7 reads back 7.
- Continuous push+pop for 3*DEPTH cycles (values 0..23) -> pointers wrap, output sequence matches input, count stays 1.
